// File: rtl/regfile_wb.sv
// RV32I integer register file with a one-entry registered write-back slot.
// Reads forward from the pending slot, never from the live wb_data input.
module regfile_wb #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int AW   = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  input  logic            wb_en,
  input  logic [AW-1:0]   wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            pend_valid,
  input  logic [AW-1:0]   dbg_addr,
  output logic [XLEN-1:0] dbg_data,
  output logic [31:0]     commit_cnt
);

  logic [XLEN-1:0] mem_q [NREG];
  logic [XLEN-1:0] mem_d [NREG];

  logic            pend_valid_q, pend_valid_d;
  logic [AW-1:0]   pend_rd_q, pend_rd_d;
  logic [XLEN-1:0] pend_data_q, pend_data_d;
  logic [31:0]     commit_cnt_q, commit_cnt_d;

  logic            cap;

  // Architectural value: x0, then pending slot, then array.
  function automatic logic [XLEN-1:0] arch_rd(
    input logic [AW-1:0] a
  );
    logic [XLEN-1:0] v;
    v = mem_q[a];
    if (a == '0) begin
      v = '0;
    end else if (pend_valid_q && a == pend_rd_q) begin
      v = pend_data_q;
    end
    return v;
  endfunction

  assign cap = wb_en && (wb_rd != '0);

  // Capture the incoming write into the slot; x0 writes are dropped.
  always_comb begin
    pend_valid_d = cap;
    pend_rd_d    = pend_rd_q;
    pend_data_d  = pend_data_q;
    if (cap) begin
      pend_rd_d   = wb_rd;
      pend_data_d = wb_data;
    end
  end

  // Commit the previously pending write into the array.
  always_comb begin
    mem_d        = mem_q;
    commit_cnt_d = commit_cnt_q;
    if (pend_valid_q && pend_rd_q != '0) begin
      mem_d[pend_rd_q] = pend_data_q;
    end
    if (pend_valid_q) begin
      commit_cnt_d = commit_cnt_q + 32'd1;
    end
  end

  // Pending slot and commit counter state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_valid_q <= 1'b0;
      pend_rd_q    <= '0;
      pend_data_q  <= '0;
      commit_cnt_q <= '0;
    end else begin
      pend_valid_q <= pend_valid_d;
      pend_rd_q    <= pend_rd_d;
      pend_data_q  <= pend_data_d;
      commit_cnt_q <= commit_cnt_d;
    end
  end

  // Register array state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  // Read ports all share the same forwarding priority.
  always_comb begin
    rs1_data = arch_rd(rs1_addr);
    rs2_data = arch_rd(rs2_addr);
    dbg_data = arch_rd(dbg_addr);
  end

  assign pend_valid = pend_valid_q;
  assign commit_cnt = commit_cnt_q;

endmodule

// File: tb/tb_regfile_wb.sv
// Scoreboard bench for regfile_wb.
// Expected post-edge values are queued at drive time, popped after the edge.
module tb_regfile_wb;

  logic        clk;
  logic        rst_n;
  logic [4:0]  rs1_addr, rs2_addr, dbg_addr, wb_rd;
  logic [31:0] rs1_data, rs2_data, dbg_data, wb_data;
  logic        wb_en;
  logic        pend_valid;
  logic [31:0] commit_cnt;

  regfile_wb dut (
    .clk(clk),
    .rst_n(rst_n),
    .rs1_addr(rs1_addr),
    .rs2_addr(rs2_addr),
    .rs1_data(rs1_data),
    .rs2_data(rs2_data),
    .wb_en(wb_en),
    .wb_rd(wb_rd),
    .wb_data(wb_data),
    .pend_valid(pend_valid),
    .dbg_addr(dbg_addr),
    .dbg_data(dbg_data),
    .commit_cnt(commit_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] r1;
    logic [31:0] r2;
    logic [31:0] dg;
    logic [31:0] cnt;
    logic        pv;
  } exp_t;

  exp_t q[$];

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] m_arr [32];
  logic        m_pv;
  logic [4:0]  m_prd;
  logic [31:0] m_pdat;
  logic [31:0] m_cnt;

  task automatic check(
    input string tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] m_rd(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (m_pv && a == m_prd) return m_pdat;
    return m_arr[a];
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 32; i++) m_arr[i] = 32'd0;
    m_pv   = 1'b0;
    m_prd  = 5'd0;
    m_pdat = 32'd0;
    m_cnt  = 32'd0;
    q.delete();
  endtask

  // One clock: drive, check no same-cycle forwarding, queue, pop after edge.
  task automatic cycle(
    input logic        en,
    input logic [4:0]  rd,
    input logic [31:0] d,
    input logic [4:0]  a1,
    input logic [4:0]  a2,
    input logic [4:0]  ad
  );
    exp_t e;
    exp_t g;
    wb_en    = en;
    wb_rd    = rd;
    wb_data  = d;
    rs1_addr = a1;
    rs2_addr = a2;
    dbg_addr = ad;
    #1;
    check("pre_rs1", rs1_data, m_rd(a1));
    check("pre_rs2", rs2_data, m_rd(a2));
    if (m_pv) begin
      m_arr[m_prd] = m_pdat;
      m_cnt = m_cnt + 32'd1;
    end
    if (en && rd != 5'd0) begin
      m_pv   = 1'b1;
      m_prd  = rd;
      m_pdat = d;
    end else begin
      m_pv = 1'b0;
    end
    e.r1  = m_rd(a1);
    e.r2  = m_rd(a2);
    e.dg  = m_rd(ad);
    e.cnt = m_cnt;
    e.pv  = m_pv;
    q.push_back(e);
    @(posedge clk);
    #1;
    g = q.pop_front();
    check("rs1", rs1_data, g.r1);
    check("rs2", rs2_data, g.r2);
    check("dbg", dbg_data, g.dg);
    check("cnt", commit_cnt, g.cnt);
    check("pv", {31'd0, pend_valid}, {31'd0, g.pv});
  endtask

  logic [31:0] base;

  initial begin
    m_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wb_en    = 1'($urandom);
      wb_rd    = 5'($urandom);
      wb_data  = $urandom;
      rs1_addr = 5'($urandom);
      rs2_addr = 5'($urandom);
      dbg_addr = 5'($urandom);
      @(posedge clk);
      #1;
      check("rst_rs1", rs1_data, 32'd0);
      check("rst_rs2", rs2_data, 32'd0);
      check("rst_dbg", dbg_data, 32'd0);
      check("rst_pv", {31'd0, pend_valid}, 32'd0);
      check("rst_cnt", commit_cnt, 32'd0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) cycle(1'b0, 5'd0, 32'd0, 5'd1, 5'd31, 5'd5);
    check("idle_cnt", commit_cnt, 32'd0);

    cycle(1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd0, 5'd5);
    check("fwd_x5", rs1_data, 32'hDEADBEEF);
    check("fwd_pv", {31'd0, pend_valid}, 32'd1);
    cycle(1'b0, 5'd0, 32'd0, 5'd5, 5'd5, 5'd5);
    check("arr_pv", {31'd0, pend_valid}, 32'd0);
    check("arr_x5", dbg_data, 32'hDEADBEEF);
    check("arr_cnt", commit_cnt, 32'd1);

    cycle(1'b1, 5'd0, 32'h12345678, 5'd0, 5'd0, 5'd0);
    check("x0_pv", {31'd0, pend_valid}, 32'd0);
    check("x0_rs2", rs2_data, 32'd0);
    check("x0_cnt", commit_cnt, 32'd1);

    base = commit_cnt;
    cycle(1'b1, 5'd7, 32'h11, 5'd7, 5'd7, 5'd7);
    cycle(1'b1, 5'd7, 32'h22, 5'd7, 5'd7, 5'd7);
    check("b2b_rs1", rs1_data, 32'h22);
    check("b2b_rs2", rs2_data, 32'h22);
    check("b2b_arr_old", dut.mem_q[7], 32'h11);
    cycle(1'b0, 5'd0, 32'd0, 5'd7, 5'd7, 5'd7);
    check("b2b_arr_new", dut.mem_q[7], 32'h22);
    check("b2b_cnt", commit_cnt - base, 32'd2);

    cycle(1'b1, 5'd3, 32'hA, 5'd3, 5'd4, 5'd3);
    cycle(1'b1, 5'd4, 32'hB, 5'd3, 5'd4, 5'd4);
    check("diff_rs1", rs1_data, 32'hA);
    check("diff_rs2", rs2_data, 32'hB);
    check("diff_arr4", dut.mem_q[4], 32'd0);

    for (int i = 0; i < 300; i++) begin
      cycle(1'($urandom), 5'($urandom), $urandom,
            5'($urandom), 5'($urandom), 5'($urandom));
    end

    cycle(1'b1, 5'd9, 32'h55, 5'd9, 5'd9, 5'd9);
    check("mid_fwd", rs1_data, 32'h55);
    rst_n = 1'b0;
    #1;
    m_reset();
    check("mid_rs1", rs1_data, 32'd0);
    check("mid_pv", {31'd0, pend_valid}, 32'd0);
    check("mid_cnt", commit_cnt, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycle(1'b0, 5'd0, 32'd0, 5'd9, 5'd9, 5'd9);
    check("mid_x9", dbg_data, 32'd0);
    check("mid_cnt2", commit_cnt, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
